rjsc5_writeback: RTL and testbench

- Retire stage of the rjsc5 core: the write-side counterpart to the half-width register file read path.
- Accepts 32-bit results from execute via valid/ready and queues them in a small FIFO.
- Serialises each result into two 16-bit register-file writes, low half then high half, on the rw_* write port consumed by both regfile_half instances.
- Exports a per-register pending mask so decode can stall on registers whose writeback has not yet completed.

---
 rtl/rjsc5_pkg.sv | 20 ++
 rtl/rjsc5_wb_fifo.sv | 63 ++++++
 rtl/rjsc5_writeback.sv | 117 +++++++++++
 tb/tb_rjsc5_writeback.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rjsc5_pkg.sv
// Shared types and widths for the rjsc5 writeback (retire) stage.
package rjsc5_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned WORD_W = 32;

    typedef struct packed {
        logic              wen;
        logic [REG_W-1:0]  rd;
        logic [WORD_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_LO,
        WB_HI
    } wb_state_t;

endpackage

// File: rtl/rjsc5_wb_fifo.sv
// Result queue for writeback: circular buffer with a per-slot valid bit,
// exposing the head plus a per-slot (wen, rd) view for the pending mask.
module rjsc5_wb_fifo
    import rjsc5_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push_i,
    input  wb_entry_t                   push_entry_i,
    input  logic                        pop_i,
    output wb_entry_t                   head_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [DEPTH-1:0]            valid_o,
    output logic [DEPTH-1:0]            wen_o,
    output logic [DEPTH-1:0][REG_W-1:0] rd_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    wb_entry_t [DEPTH-1:0] mem_q;
    logic      [DEPTH-1:0] valid_q;
    logic      [PTR_W-1:0] wr_ptr_q;
    logic      [PTR_W-1:0] rd_ptr_q;

    // Callers never push when full nor pop when empty, so the two slots differ.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '0;
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q]   <= push_entry_i;
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Power-of-two ring: the write slot is occupied only when every slot is.
    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = valid_q[wr_ptr_q];
    assign empty_o = !valid_q[rd_ptr_q];
    assign valid_o = valid_q;

    always_comb begin
        wen_o = '0;
        rd_o  = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            wen_o[i] = valid_q[i] && mem_q[i].wen;
            rd_o[i]  = mem_q[i].rd;
        end
    end

endmodule

// File: rtl/rjsc5_writeback.sv
// rjsc5 retire stage: queues 32-bit results and writes each one to the
// half-width register file as a low-half then high-half strobe.
module rjsc5_writeback
    import rjsc5_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ex_wen,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic [WORD_W-1:0] ex_result,
    output logic              rw_clken,
    output logic              rw_half,
    output logic [REG_W-1:0]  rw_rd,
    output logic [HALF_W-1:0] rw_result,
    output logic              rw_retire,
    output logic [WORD_W-1:0] rw_pending
);

    wb_state_t                   state_q, state_d;
    wb_entry_t                   head;
    wb_entry_t                   push_entry;
    logic                        full;
    logic                        empty;
    logic                        push;
    logic                        pop;
    logic                        more_queued;
    logic [DEPTH-1:0]            valid;
    logic [DEPTH-1:0]            slot_wen;
    logic [DEPTH-1:0][REG_W-1:0] slot_rd;

    assign ex_ready = !full;
    assign push     = ex_valid && !full;

    // x0 is hardwired zero, so such results retire as skips.
    assign push_entry = '{wen: ex_wen && (ex_rd != '0), rd: ex_rd, data: ex_result};

    // Clears the lowest set bit: nonzero means an entry sits behind the head.
    assign more_queued = |(valid & (valid - DEPTH'(1)));

    rjsc5_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (head),
        .full_o       (full),
        .empty_o      (empty),
        .valid_o      (valid),
        .wen_o        (slot_wen),
        .rd_o         (slot_rd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= WB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        rw_clken  = 1'b0;
        rw_half   = 1'b0;
        rw_rd     = '0;
        rw_result = '0;
        rw_retire = 1'b0;
        unique case (state_q)
            WB_IDLE: begin
                if (push) begin
                    state_d = WB_LO;
                end
            end
            WB_LO: begin
                if (head.wen) begin
                    rw_clken  = 1'b1;
                    rw_rd     = head.rd;
                    rw_result = head.data[HALF_W-1:0];
                    state_d   = WB_HI;
                end else begin
                    rw_retire = 1'b1;
                    pop       = !empty;
                end
            end
            WB_HI: begin
                rw_clken  = 1'b1;
                rw_half   = 1'b1;
                rw_rd     = head.rd;
                rw_result = head.data[WORD_W-1:HALF_W];
                rw_retire = 1'b1;
                pop       = 1'b1;
            end
            default: state_d = WB_IDLE;
        endcase
        if (pop) begin
            state_d = (more_queued || push) ? WB_LO : WB_IDLE;
        end
    end

    always_comb begin
        rw_pending = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (slot_wen[i]) begin
                rw_pending[slot_rd[i]] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rjsc5_writeback.sv
// Bench for rjsc5_writeback: queue-of-results reference model, directed
// scenarios followed by random traffic.
module tb_rjsc5_writeback;
    import rjsc5_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_wen;
    logic [4:0]  ex_rd;
    logic [31:0] ex_result;
    logic        rw_clken;
    logic        rw_half;
    logic [4:0]  rw_rd;
    logic [15:0] rw_result;
    logic        rw_retire;
    logic [31:0] rw_pending;

    rjsc5_writeback #(
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_wen     (ex_wen),
        .ex_rd      (ex_rd),
        .ex_result  (ex_result),
        .rw_clken   (rw_clken),
        .rw_half    (rw_half),
        .rw_rd      (rw_rd),
        .rw_result  (rw_result),
        .rw_retire  (rw_retire),
        .rw_pending (rw_pending)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Model: queue of accepted results; a writing result takes two beats,
    // a non-writing one a single beat.
    typedef struct {
        logic        wen;
        logic [4:0]  rd;
        logic [31:0] data;
        bit          lo_done;
    } m_ent_t;

    m_ent_t      mq[$];
    logic [5:0]  wlog[$];
    bit          stall_seen;

    task automatic check_outputs();
        logic        e_clken  = 1'b0;
        logic        e_half   = 1'b0;
        logic        e_retire = 1'b0;
        logic [4:0]  e_rd     = '0;
        logic [15:0] e_res    = '0;
        logic [31:0] e_pend   = '0;
        logic [31:0] w;
        if (mq.size() > 0) begin
            w = mq[0].data;
            if (!mq[0].wen) begin
                e_retire = 1'b1;
            end else if (!mq[0].lo_done) begin
                e_clken = 1'b1;
                e_rd    = mq[0].rd;
                e_res   = w[15:0];
            end else begin
                e_clken  = 1'b1;
                e_half   = 1'b1;
                e_rd     = mq[0].rd;
                e_res    = w[31:16];
                e_retire = 1'b1;
            end
        end
        foreach (mq[i]) begin
            if (mq[i].wen) e_pend[mq[i].rd] = 1'b1;
        end
        check("ex_ready", 32'(ex_ready), 32'(mq.size() < int'(DEPTH)));
        check("rw_clken", 32'(rw_clken), 32'(e_clken));
        check("rw_half", 32'(rw_half), 32'(e_half));
        check("rw_rd", 32'(rw_rd), 32'(e_rd));
        check("rw_result", 32'(rw_result), 32'(e_res));
        check("rw_retire", 32'(rw_retire), 32'(e_retire));
        check("rw_pending", rw_pending, e_pend);
        if (!ex_ready) stall_seen = 1'b1;
        if (rw_clken) wlog.push_back({rw_half, rw_rd});
    endtask

    task automatic step(input logic v, input logic w, input logic [4:0] rd,
                        input logic [31:0] d, output bit acc);
        @(negedge clk);
        check_outputs();
        ex_valid  = v;
        ex_wen    = w;
        ex_rd     = rd;
        ex_result = d;
        acc = v && (mq.size() < int'(DEPTH));
        @(posedge clk);
        if (mq.size() > 0) begin
            if (mq[0].wen && !mq[0].lo_done) mq[0].lo_done = 1'b1;
            else void'(mq.pop_front());
        end
        if (acc) mq.push_back('{wen: w && (rd != 5'd0), rd: rd, data: d, lo_done: 1'b0});
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'd0, acc);
    endtask

    task automatic push_hold(input logic w, input logic [4:0] rd, input logic [31:0] d);
        bit acc = 1'b0;
        int n = 0;
        while (!acc && n < 20) begin
            step(1'b1, w, rd, d, acc);
            n++;
        end
        check("push_accepted", 32'(acc), 32'd1);
    endtask

    initial begin
        bit          acc;
        logic        v;
        logic        w;
        logic [4:0]  rd;
        logic [5:0]  exp_seq[6];

        reset     = 1'b1;
        ex_valid  = 1'b0;
        ex_wen    = 1'b0;
        ex_rd     = '0;
        ex_result = '0;
        stall_seen = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Single write, then an x0 write that must turn into a skip.
        idle(1);
        step(1'b1, 1'b1, 5'd5, 32'h1234_ABCD, acc);
        idle(4);
        step(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, acc);
        idle(3);

        // Backpressure with three held results.
        wlog.delete();
        stall_seen = 1'b0;
        push_hold(1'b1, 5'd1, 32'h0001_0001);
        push_hold(1'b1, 5'd2, 32'h0002_0002);
        push_hold(1'b1, 5'd3, 32'h0003_0003);
        idle(6);
        check("stall_seen", 32'(stall_seen), 32'd1);
        exp_seq = '{6'h01, 6'h21, 6'h02, 6'h22, 6'h03, 6'h23};
        check("bp_write_count", 32'(wlog.size()), 32'd6);
        for (int i = 0; i < 6 && i < wlog.size(); i++) begin
            check("bp_write_seq", 32'(wlog[i]), 32'(exp_seq[i]));
        end

        // Skip between two writes.
        push_hold(1'b1, 5'd4, 32'h4444_4444);
        push_hold(1'b0, 5'd9, 32'h9999_9999);
        push_hold(1'b1, 5'd6, 32'h6666_6666);
        idle(5);

        // Asynchronous reset while the high half of rd 7 is on the port.
        step(1'b1, 1'b1, 5'd7, 32'h7777_0007, acc);
        idle(1);
        @(negedge clk);
        check_outputs();
        #2 reset = 1'b1;
        #1;
        check("rst_clken", 32'(rw_clken), 32'd0);
        check("rst_pending", rw_pending, 32'd0);
        check("rst_ready", 32'(ex_ready), 32'd1);
        mq.delete();
        @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        wlog.delete();
        idle(4);
        check("rst_no_write", 32'(wlog.size()), 32'd0);

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            v  = ($urandom_range(0, 3) != 0);
            w  = ($urandom_range(0, 4) != 0);
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            step(v, w, rd, $urandom, acc);
        end
        idle(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
